// File: rtl/qtree_cfg_pkg.sv
// Shared types for the quadtree configuration path: command payload,
// node layout and the per-stage address width rule.
package qtree_cfg_pkg;

  localparam int unsigned CFG_STAGES  = 4;
  localparam int unsigned CFG_STAGE_W = (CFG_STAGES > 1) ? $clog2(CFG_STAGES) : 1;
  localparam int unsigned CFG_ADDR_W  = (2 * (CFG_STAGES - 1) > 1) ? 2 * (CFG_STAGES - 1) : 1;
  localparam int unsigned CFG_KEY_W   = 16;
  localparam int unsigned NODE_W      = 3 * CFG_KEY_W;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_CLEAR = 1'b1
  } cfg_op_t;

  typedef struct packed {
    logic [CFG_KEY_W-1:0] l;
    logic [CFG_KEY_W-1:0] m;
    logic [CFG_KEY_W-1:0] r;
  } ram_data_t;

  typedef struct packed {
    cfg_op_t                op;
    logic [CFG_STAGE_W-1:0] stage;
    logic [CFG_ADDR_W-1:0]  addr;
    ram_data_t              data;
  } cfg_cmd_t;

  // Node-table address width of stage s: max(1, 2*s).
  function automatic int unsigned stage_aw(input int unsigned s);
    return (2 * s > 1) ? 2 * s : 1;
  endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Command FIFO for qstage_cfg_ctrl.
// Ports: clk_i/rst_i (async, active-high), push_i + push_data_i write,
// pop_i advances the head, head_c is the combinational head entry,
// full_o/empty_o are registered occupancy flags.
// Callers never push when full nor pop when empty.
module cfg_cmd_fifo
  import qtree_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  cfg_cmd_t push_data_i,
  input  logic     pop_i,
  output cfg_cmd_t head_c,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  cfg_cmd_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_c;

  // Occupancy after this edge; flags are registered from it.
  always_comb begin
    count_c = count_q;
    if (push_i && !pop_i) begin
      count_c = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_c = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_c;
      full_o  <= (count_c == CW'(DEPTH));
      empty_o <= (count_c == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/qstage_cfg_ctrl.sv
// Configuration controller for the quadtree lookup pipeline.
// Buffers host WRITE/CLEAR commands and turns them into one-hot,
// single-cycle node-table write strobes, one write per cycle.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cmd_valid_i/ready_o command handshake (ready = !fifo_full, registered)
//   cmd_op_i/stage_i/addr_i/data_i  command fields
//   wr_en_o/addr_o/data_o  registered write bus shared by all stages
//   busy_o, done_o, err_o  status; err_o marks a dropped command
// Command payload widths come from qtree_cfg_pkg; ADDR_WIDTH and
// DATA_WIDTH are expected to match them.
module qstage_cfg_ctrl
  import qtree_cfg_pkg::*;
#(
  parameter int unsigned STAGES     = CFG_STAGES,
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_W,
  parameter int unsigned DATA_WIDTH = CFG_KEY_W,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SW        = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int unsigned DW3       = 3 * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_op_i,
  input  logic [SW-1:0]         cmd_stage_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DW3-1:0]        cmd_data_i,
  output logic [STAGES-1:0]     wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DW3-1:0]        wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CFG_STAGE_W-1:0] stage_q;
  logic [CFG_ADDR_W-1:0]  addr_q;
  ram_data_t              data_q;
  logic [CFG_ADDR_W-1:0]  cnt_q;
  logic [CFG_ADDR_W-1:0]  last_c;

  cfg_cmd_t push_cmd;
  cfg_cmd_t head;
  logic     push_c;
  logic     pop_c;
  logic     fifo_full;
  logic     fifo_empty;

  assign cmd_ready_o = ~fifo_full;
  assign push_c      = cmd_valid_i & cmd_ready_o;
  assign pop_c       = (state_q == ST_IDLE) & ~fifo_empty;

  always_comb begin
    push_cmd       = '0;
    push_cmd.op    = cfg_op_t'(cmd_op_i);
    push_cmd.stage = CFG_STAGE_W'(cmd_stage_i);
    push_cmd.addr  = CFG_ADDR_W'(cmd_addr_i);
    push_cmd.data  = ram_data_t'(NODE_W'(cmd_data_i));
  end

  cfg_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_c),
    .push_data_i(push_cmd),
    .pop_i      (pop_c),
    .head_c     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Final sweep address of the stage being cleared.
  assign last_c = CFG_ADDR_W'((32'd1 << stage_aw(32'(stage_q))) - 32'd1);

  // Sequencer: pop in IDLE, then one WRITE strobe or a full CLEAR sweep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      wr_en_o   <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      wr_en_o <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      // Stays high through the final done_o cycle, drops one cycle later.
      busy_o  <= (state_q != ST_IDLE) | ~fifo_empty | push_c;

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            stage_q <= head.stage;
            addr_q  <= head.addr;
            data_q  <= head.data;
            cnt_q   <= '0;
            if (32'(head.stage) >= STAGES) begin
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else if (head.op == OP_CLEAR) begin
              state_q <= ST_CLEAR;
            end else begin
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          wr_en_o   <= STAGES'(1) << stage_q;
          wr_addr_o <= ADDR_WIDTH'(addr_q);
          wr_data_o <= DW3'(data_q);
          done_o    <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_CLEAR: begin
          // All-ones nodes steer every key to child 0.
          wr_en_o   <= STAGES'(1) << stage_q;
          wr_addr_o <= ADDR_WIDTH'(cnt_q);
          wr_data_o <= '1;
          cnt_q     <= cnt_q + CFG_ADDR_W'(1);
          if (cnt_q == last_c) begin
            done_o  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qstage_cfg_ctrl.sv
// Self-checking bench for qstage_cfg_ctrl: a 4-stage instance (a_*) and a
// 3-stage instance (b_*) used for the out-of-range stage case.
module tb_qstage_cfg_ctrl;
  import qtree_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic        a_valid = 1'b0, a_op = 1'b0;
  logic [1:0]  a_stage = '0;
  logic [5:0]  a_addr = '0;
  logic [47:0] a_data = '0;
  logic        a_ready, a_busy, a_done, a_err;
  logic [3:0]  a_wr_en;
  logic [5:0]  a_wr_addr;
  logic [47:0] a_wr_data;

  logic        b_valid = 1'b0, b_op = 1'b0;
  logic [1:0]  b_stage = '0;
  logic [5:0]  b_addr = '0;
  logic [47:0] b_data = '0;
  logic        b_ready, b_busy, b_done, b_err;
  logic [2:0]  b_wr_en;
  logic [5:0]  b_wr_addr;
  logic [47:0] b_wr_data;

  qstage_cfg_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(a_valid), .cmd_ready_o(a_ready), .cmd_op_i(a_op),
    .cmd_stage_i(a_stage), .cmd_addr_i(a_addr), .cmd_data_i(a_data),
    .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
  );

  qstage_cfg_ctrl #(.STAGES(3), .ADDR_WIDTH(6)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(b_valid), .cmd_ready_o(b_ready), .cmd_op_i(b_op),
    .cmd_stage_i(b_stage), .cmd_addr_i(b_addr), .cmd_data_i(b_data),
    .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
  );

  typedef struct packed {
    logic [3:0]  en;
    logic [5:0]  addr;
    logic [47:0] data;
    logic        done;
    logic        err;
  } ev_t;

  ev_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  int  cyc_a[$], cyc_b[$];
  logic [5:0]  last_addr[2];
  logic [47:0] last_data[2];

  // Observe every strobe / done / err cycle of both instances.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (a_wr_en != 0 || a_done || a_err) begin
        e = '{a_wr_en, a_wr_addr, a_wr_data, a_done, a_err};
        obs_a.push_back(e);
        cyc_a.push_back(cyc);
      end
      if (b_wr_en != 0 || b_done || b_err) begin
        e = '{{1'b0, b_wr_en}, b_wr_addr, b_wr_data, b_done, b_err};
        obs_b.push_back(e);
        cyc_b.push_back(cyc);
      end
    end
  end

  // Reference: expected write stream of one accepted command.
  task automatic model_cmd(input int sel, input logic op, input int unsigned stage,
                           input logic [5:0] addr, input logic [47:0] data);
    ev_t e;
    int unsigned nst = (sel == 1) ? 3 : 4;
    int unsigned n;
    if (stage >= nst) begin
      e = '{4'b0, last_addr[sel], last_data[sel], 1'b1, 1'b1};
      if (sel == 1) exp_b.push_back(e); else exp_a.push_back(e);
    end else if (op == 1'b0) begin
      e = '{4'(1 << stage), addr, data, 1'b1, 1'b0};
      last_addr[sel] = addr;
      last_data[sel] = data;
      if (sel == 1) exp_b.push_back(e); else exp_a.push_back(e);
    end else begin
      n = 1 << ((stage == 0) ? 1 : 2 * stage);
      for (int unsigned i = 0; i < n; i++) begin
        e = '{4'(1 << stage), 6'(i), {48{1'b1}}, (i == n - 1), 1'b0};
        if (sel == 1) exp_b.push_back(e); else exp_a.push_back(e);
      end
      last_addr[sel] = 6'(n - 1);
      last_data[sel] = {48{1'b1}};
    end
  endtask

  // Present a command and hold it stable until accepted; acc = cycle count
  // sampled at the negedge before the accepting edge.
  task automatic send(input int sel, input logic op, input logic [1:0] stage,
                      input logic [5:0] addr, input logic [47:0] data, output int acc);
    int budget = 0;
    @(negedge clk);
    if (sel == 1) begin
      b_valid = 1'b1; b_op = op; b_stage = stage; b_addr = addr; b_data = data;
    end else begin
      a_valid = 1'b1; a_op = op; a_stage = stage; a_addr = addr; a_data = data;
    end
    while (((sel == 1) ? b_ready : a_ready) !== 1'b1 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    acc = cyc;
    if (budget >= 3000) begin
      checks++; errors++;
      $display("FAIL send_timeout sel=%0d: ready never rose within %0d cycles", sel, budget);
    end else begin
      @(posedge clk);
      model_cmd(sel, op, 32'(stage), addr, data);
    end
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int budget = 0;
    @(negedge clk);
    while (((sel == 1) ? b_busy : a_busy) !== 1'b0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout sel=%0d: busy still high after %0d cycles", sel, budget);
    end
  endtask

  task automatic clear_q();
    exp_a.delete(); obs_a.delete(); cyc_a.delete();
    exp_b.delete(); obs_b.delete(); cyc_b.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_addr[0] = '0; last_data[0] = '0;
    last_addr[1] = '0; last_data[1] = '0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", a_ready); end
    checks++; if (a_wr_en !== 4'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", a_wr_en); end
    checks++; if (a_wr_addr !== 6'd0) begin errors++; $display("FAIL rst_wr_addr got %h want 0", a_wr_addr); end
    checks++; if (a_wr_data !== 48'd0) begin errors++; $display("FAIL rst_wr_data got %h want 0", a_wr_data); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_busy); end
    checks++; if ({a_done, a_err} !== 2'b00) begin errors++; $display("FAIL rst_done_err got %b want 00", {a_done, a_err}); end
    checks++; if ({b_ready, b_busy, b_wr_en} !== 5'b10000) begin errors++; $display("FAIL rst_b got %b want 10000", {b_ready, b_busy, b_wr_en}); end
    clear_q();
  endtask

  task automatic test_single_write();
    int acc;
    clear_q();
    send(0, 1'b0, 2'd2, 6'd5, {16'h0010, 16'h0020, 16'h0030}, acc);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL write_busy_rise got %b want 1", a_busy); end
    wait_idle(0);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL write_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL write_ev%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    if (cyc_a.size() > 0) begin
      checks++;
      if (cyc_a[0] != acc + 3) begin errors++; $display("FAIL write_latency got %0d want %0d", cyc_a[0] - acc, 3); end
    end
  endtask

  task automatic test_clear(input logic [1:0] stage);
    int acc;
    clear_q();
    send(0, 1'b1, stage, $urandom, 48'($urandom), acc);
    wait_idle(0);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL clear%0d_count got %0d want %0d", stage, obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL clear%0d_ev%0d got %h want %h", stage, i, obs_a[i], exp_a[i]); end
      checks++;
      if (cyc_a[i] != acc + 3 + i) begin errors++; $display("FAIL clear%0d_cycle%0d got %0d want %0d", stage, i, cyc_a[i], acc + 3 + i); end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_q();
    for (int i = 0; i < 6; i++) send(0, 1'b0, 2'($urandom), 6'($urandom), {$urandom, 16'($urandom)}, acc);
    wait_idle(0);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL b2b_ev%0d got %h want %h", i, obs_a[i], exp_a[i]); end
      if (i > 0) begin
        checks++;
        if (cyc_a[i] - cyc_a[i-1] != 2) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 2", i, cyc_a[i] - cyc_a[i-1]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int acc;
    clear_q();
    send(0, 1'b1, 2'd3, 6'd0, 48'd0, acc);
    for (int i = 0; i < 6; i++) begin
      send(0, 1'b0, 2'($urandom), 6'($urandom), {$urandom, 16'($urandom)}, acc);
      if (i == 3) begin
        checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after4 got %b want 0", a_ready); end
      end
    end
    wait_idle(0);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL bp_ev%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_bad_stage();
    int acc;
    clear_q();
    send(1, 1'b0, 2'd3, 6'($urandom), 48'($urandom), acc);
    send(1, 1'b0, 2'd2, 6'd9, 48'h1234_5678_9abc, acc);
    send(1, 1'b1, 2'd3, 6'd0, 48'd0, acc);
    wait_idle(1);
    checks++;
    if (obs_b.size() != exp_b.size()) begin errors++; $display("FAIL bad_count got %0d want %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      checks++;
      if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL bad_ev%0d got %h want %h", i, obs_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_random();
    int acc;
    logic op;
    logic [1:0] st;
    clear_q();
    for (int i = 0; i < 20; i++) begin
      op = 1'($urandom);
      st = op ? 2'($urandom_range(0, 2)) : 2'($urandom);
      send(0, op, st, 6'($urandom), {$urandom, 16'($urandom)}, acc);
    end
    wait_idle(0);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL rand_ev%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int acc;
    int budget = 0;
    clear_q();
    send(0, 1'b1, 2'd3, 6'd0, 48'd0, acc);
    while (!(a_wr_en == 4'b1000 && a_wr_addr == 6'd10) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 200) begin errors++; $display("FAIL mid_sweep_reach got addr %0d want 10", a_wr_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_wr_en !== 4'b0) begin errors++; $display("FAIL mid_rst_wr_en got %b want 0", a_wr_en); end
    checks++; if ({a_ready, a_busy} !== 2'b10) begin errors++; $display("FAIL mid_rst_ready_busy got %b want 10", {a_ready, a_busy}); end
    @(negedge clk);
    rst = 1'b0;
    last_addr[0] = '0; last_data[0] = '0;
    last_addr[1] = '0; last_data[1] = '0;
    clear_q();
    send(0, 1'b0, 2'd1, 6'd3, 48'hdead_beef_0001, acc);
    wait_idle(0);
    checks++;
    if (obs_a.size() != 1 || exp_a.size() != 1) begin
      errors++; $display("FAIL mid_after_count got %0d want 1", obs_a.size());
    end else begin
      checks++;
      if (obs_a[0] !== exp_a[0]) begin errors++; $display("FAIL mid_after_ev got %h want %h", obs_a[0], exp_a[0]); end
      checks++;
      if (cyc_a[0] != acc + 3) begin errors++; $display("FAIL mid_after_latency got %0d want 3", cyc_a[0] - acc); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_clear(2'd1);
    test_clear(2'd0);
    test_back_to_back();
    test_back_pressure();
    test_bad_stage();
    test_random();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
